// File: rtl/count_sched_pkg.sv
// Shared types and constants for the two-requester counter scheduler.
package count_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int   WIDTH_DEF = 4;
    localparam logic REQ0      = 1'b0;
    localparam logic REQ1      = 1'b1;

endpackage

// File: rtl/count_scheduler_load_counter.sv
// Shared up-counter datapath: synchronous clear (dominant) and count enable.
module load_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/count_scheduler.sv
// Round-robin owner of the shared counter: arbitrates two requesters, paces the
// run with tick, and pulses done to the owner when the terminal count is reached.
module count_scheduler
    import count_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             tick,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q,  last_d;
    logic [WIDTH-1:0] len_q,   len_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       done_q,  done_d;
    logic             busy_q,  busy_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             winner;

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (req == 2'b11) begin
            winner = ~last_q;
        end else begin
            winner = req[1] ? REQ1 : REQ0;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        len_d   = len_q;
        grant_d = grant_q;
        done_d  = 2'b00;
        busy_d  = busy_q;
        cnt_clr = 1'b1;
        cnt_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                if (req != 2'b00) begin
                    owner_d = winner;
                    len_d   = (winner == REQ1) ? len1 : len0;
                    grant_d = (winner == REQ1) ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_clr = 1'b0;
                if (!req[owner_q]) begin
                    // Owner withdrew: release without a completion pulse.
                    cnt_clr = 1'b1;
                    last_d  = owner_q;
                    grant_d = 2'b00;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (count == len_q) begin
                    done_d  = grant_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_en = tick;
                end
            end
            ST_DONE: begin
                last_d  = owner_q;
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= REQ0;
            last_q  <= REQ1;
            len_q   <= '0;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            len_q   <= len_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    load_counter #(
        .WIDTH (WIDTH)
    ) u_load_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_count_scheduler.sv
// Self-checking bench for count_scheduler: directed scenarios plus randomized
// back-to-back runs checked against a run-level arithmetic model.
module tb_count_scheduler;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic             tick;
    logic [1:0]       grant;
    logic [1:0]       done;
    logic             busy;
    logic [WIDTH-1:0] count;

    int n_tests;
    int n_fail;

    count_scheduler #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .tick  (tick),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling outputs.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 2'b11; len0 = 4'd3; len1 = 4'd3; tick = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
            n_tests++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", done); end
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
            n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        end
        reset = 1'b1;
    endtask

    // Both requests held high from reset release: service must go 0,1,0.
    task automatic test_tie_rr();
        logic [1:0] oh;
        int         lim;
        int         waited;
        len0 = 4'd2; len1 = 4'd1; req = 2'b11; tick = 1'b1;
        for (int r = 0; r < 3; r++) begin
            oh  = (r % 2 == 1) ? 2'b10 : 2'b01;
            lim = (r % 2 == 1) ? 1 : 2;
            cyc();
            n_tests++; if (grant !== oh) begin n_fail++; $display("FAIL rr_grant run%0d: got %b want %b", r, grant, oh); end
            n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL rr_count0 run%0d: got %0d want 0", r, count); end
            waited = 0;
            do begin
                cyc();
                waited++;
            end while (done === 2'b00 && waited < 40);
            n_tests++; if (waited != lim + 1) begin n_fail++; $display("FAIL rr_latency run%0d: got %0d want %0d", r, waited, lim + 1); end
            n_tests++; if (done !== oh || grant !== oh) begin n_fail++; $display("FAIL rr_done run%0d: done %b grant %b want %b", r, done, grant, oh); end
            if (r == 2) req = 2'b00;
            cyc();
            n_tests++; if (grant !== 2'b00 || done !== 2'b00 || count !== 4'd0) begin
                n_fail++; $display("FAIL rr_idle run%0d: grant %b done %b count %0d want 00 00 0", r, grant, done, count);
            end
        end
    endtask

    task automatic test_reset_midrun();
        req = 2'b01; len0 = 4'd9; tick = 1'b1;
        cyc();
        n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL midrst_grant: got %b want 01", grant); end
        repeat (5) cyc();
        n_tests++; if (count !== 4'd5) begin n_fail++; $display("FAIL midrst_count5: got %0d want 5", count); end
        reset = 1'b0; req = 2'b11;
        cyc();
        n_tests++; if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || count !== 4'd0) begin
            n_fail++; $display("FAIL midrst_outputs: grant %b done %b busy %b count %0d want all 0", grant, done, busy, count);
        end
        reset = 1'b1;
        cyc();
        n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL midrst_tie: got %b want 01", grant); end
        req = 2'b00;
        cyc();
        n_tests++; if (grant !== 2'b00 || done !== 2'b00) begin n_fail++; $display("FAIL midrst_release: grant %b done %b want 00 00", grant, done); end
    endtask

    task automatic test_zero_stall();
        len1 = 4'd0; req = 2'b10; tick = 1'b1;
        cyc();
        n_tests++; if (grant !== 2'b10 || count !== 4'd0) begin n_fail++; $display("FAIL zero_grant: grant %b count %0d want 10 0", grant, count); end
        cyc();
        n_tests++; if (done !== 2'b10 || grant !== 2'b10) begin n_fail++; $display("FAIL zero_done: done %b grant %b want 10 10", done, grant); end
        req = 2'b00;
        cyc();
        n_tests++; if (grant !== 2'b00 || done !== 2'b00) begin n_fail++; $display("FAIL zero_idle: grant %b done %b want 00 00", grant, done); end
        len0 = 4'd2; req = 2'b01;
        cyc();
        n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL stall_grant: got %b want 01", grant); end
        cyc();
        n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL stall_count1: got %0d want 1", count); end
        tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++; if (count !== 4'd1 || done !== 2'b00) begin n_fail++; $display("FAIL stall_hold%0d: count %0d done %b want 1 00", i, count, done); end
        end
        tick = 1'b1;
        cyc();
        n_tests++; if (count !== 4'd2 || done !== 2'b00) begin n_fail++; $display("FAIL stall_count2: count %0d done %b want 2 00", count, done); end
        cyc();
        n_tests++; if (done !== 2'b01 || count !== 4'd2) begin n_fail++; $display("FAIL stall_done: done %b count %0d want 01 2", done, count); end
        req = 2'b00;
        cyc();
    endtask

    task automatic test_abort();
        int waited;
        req = 2'b01; len0 = 4'd5; len1 = 4'd1; tick = 1'b1;
        cyc();
        n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL abort_grant0: got %b want 01", grant); end
        req = 2'b11;
        cyc();
        cyc();
        n_tests++; if (count !== 4'd2 || grant !== 2'b01) begin n_fail++; $display("FAIL abort_pre: count %0d grant %b want 2 01", count, grant); end
        req = 2'b10;
        cyc();
        n_tests++; if (grant !== 2'b00 || count !== 4'd0 || done !== 2'b00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_release: grant %b count %0d done %b busy %b want 00 0 00 0", grant, count, done, busy);
        end
        cyc();
        n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL abort_next: got %b want 10", grant); end
        waited = 0;
        do begin
            cyc();
            waited++;
        end while (done === 2'b00 && waited < 40);
        n_tests++; if (waited != 2 || done !== 2'b10) begin n_fail++; $display("FAIL abort_done1: waited %0d done %b want 2 10", waited, done); end
        req = 2'b00;
        cyc();
    endtask

    // Both requests held; each run's length and tick pattern are random.
    // Expected count is min(len, ticks seen since grant); done follows the
    // first cycle where count equals len; grant alternates between requesters.
    task automatic test_random();
        logic       exp_owner;
        logic [1:0] oh;
        int         run_len;
        int         exp_cnt;
        int         guard;
        logic       t;
        exp_owner = 1'b0;
        req = 2'b11;
        for (int r = 0; r < 25; r++) begin
            len0 = WIDTH'($urandom_range(0, 15));
            len1 = WIDTH'($urandom_range(0, 15));
            tick = ($urandom_range(0, 3) != 0);
            run_len = exp_owner ? int'(len1) : int'(len0);
            oh = exp_owner ? 2'b10 : 2'b01;
            cyc();
            n_tests++; if (grant !== oh || count !== 4'd0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL rand_grant run%0d: grant %b count %0d busy %b want %b 0 1", r, grant, count, busy, oh);
            end
            exp_cnt = 0;
            guard = 0;
            forever begin
                len0 = WIDTH'($urandom_range(0, 15));
                len1 = WIDTH'($urandom_range(0, 15));
                t = ($urandom_range(0, 3) != 0);
                tick = t;
                cyc();
                guard++;
                if (exp_cnt == run_len) begin
                    n_tests++; if (done !== oh || grant !== oh || int'(count) != run_len) begin
                        n_fail++; $display("FAIL rand_done run%0d: done %b grant %b count %0d want %b %b %0d", r, done, grant, count, oh, oh, run_len);
                    end
                    break;
                end
                if (t) exp_cnt++;
                n_tests++; if (int'(count) != exp_cnt || done !== 2'b00 || grant !== oh) begin
                    n_fail++; $display("FAIL rand_run run%0d: count %0d done %b grant %b want %0d 00 %b", r, count, done, grant, exp_cnt, oh);
                    break;
                end
                if (guard > 200) begin
                    n_tests++; n_fail++; $display("FAIL rand_timeout run%0d: no completion after %0d cycles", r, guard);
                    break;
                end
            end
            if (r == 24) req = 2'b00;
            cyc();
            n_tests++; if (grant !== 2'b00 || count !== 4'd0 || busy !== 1'b0 || done !== 2'b00) begin
                n_fail++; $display("FAIL rand_idle run%0d: grant %b count %0d busy %b done %b want 00 0 0 00", r, grant, count, busy, done);
            end
            exp_owner = ~exp_owner;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0; req = 2'b00; len0 = '0; len1 = '0; tick = 1'b0;
        test_reset();
        test_tie_rr();
        test_reset_midrun();
        test_zero_stall();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
